mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
//   Memory/IO bus controller directly downstream of the CPU core. Consumes the core's
//   mem_cmd/mem_addr/write-data and services each request from a synchronous 256x16 RAM
//   (1-cycle registered read) or memory-mapped LED/switch registers.
//   Returns read data and a one-cycle mem_ready pulse per completed access; flags unmapped/illegal requests.
// PARAMETERS
//   ADDR_W    9       width of mem_addr
//   DATA_W    16      data word width
//   RAM_AW    8       RAM address width (RAM_DEPTH = 2**RAM_AW words, at mem_addr[8]==0)
//   LED_ADDR  9'h100  write-only LED register address
//   SW_ADDR   9'h140  read-only switch register address
// PORTS
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous, active-low reset
//   mem_cmd     in   2       00 NONE, 01 READ, 10 WRITE, 11 reserved (illegal)
//   mem_addr    in   ADDR_W  word address from core
//   write_data  in   DATA_W  store data from core
//   read_data   out  DATA_W  registered load data; holds until next successful read
//   mem_ready   out  1       1-cycle pulse: current access complete
//   bus_err     out  1       1-cycle pulse, coincident with mem_ready, on unmapped/illegal access
//   ram_addr    out  RAM_AW  RAM address (registered at accept)
//   ram_we      out  1       RAM write enable
//   ram_wdata   out  DATA_W  RAM write data (registered at accept)
//   ram_rdata   in   DATA_W  RAM read data, valid one cycle after ram_addr presented
//   sw_in       in   8       asynchronous slide switches
//   led_out     out  8       LED register
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; read_data=0, mem_ready=0, bus_err=0, ram_we=0,
//     ram_addr=0, ram_wdata=0, led_out=0, switch synchronizer=0. Reset mid-access aborts it:
//     no write committed, no mem_ready issued.
//   sw_in passes through a 2-flop synchronizer; SW reads return {8'h00, sw_sync}.
//   FSM states: IDLE, RD_WAIT, RD_CAP, WR, RESP.
//   IDLE: if mem_cmd!=NONE, accept: latch addr/data/cmd, decode:
//     READ,  addr[8]==0  -> RD_WAIT (ram_addr<=addr[7:0])
//     WRITE, addr[8]==0  -> WR (ram_addr<=addr[7:0], ram_wdata<=write_data)
//     READ,  SW_ADDR     -> RESP, read_data<=sw_sync
//     WRITE, LED_ADDR    -> RESP, led_out<=write_data[7:0]
//     cmd 11, WRITE to SW_ADDR, READ of LED_ADDR, any other addr -> RESP with bus_err;
//       no state (read_data/led_out/RAM) modified.
//   RD_WAIT: RAM fetching -> RD_CAP.  RD_CAP: read_data<=ram_rdata -> RESP.
//   WR: ram_we=1 for exactly this cycle -> RESP.
//   RESP: mem_ready=1 (and bus_err if flagged) for exactly one cycle -> IDLE.
//   Latency accept->mem_ready: RAM read 3 cycles, RAM write 2, IO/error 1.
//   mem_ready/bus_err are registered outputs (asserted in RESP, low all other states).
//   Handshake: core holds request until it sees mem_ready, then drives NONE next cycle;
//     inputs are ignored outside IDLE; a request still present in IDLE is a new access
//     (back-to-back allowed, IDLE one cycle between accesses).
//   read_data updates only on successful reads; writes and errors leave it unchanged.
//   Address wrap: none; addr[7:0] maps RAM directly, addr 9'h0FF is last RAM word.
// TESTING
//   1 rst_n low mid RD_WAIT -> state IDLE, all outputs 0, no mem_ready after release.
//   2 WRITE 9'h005 data 16'hBEEF, then READ 9'h005 -> ram_we one cycle with ram_addr 8'h05;
//     read mem_ready 3 cycles after accept, read_data=16'hBEEF.
//   3 WRITE LED_ADDR data 16'h12A5 -> led_out=8'hA5, mem_ready 1 cycle after accept, bus_err=0.
//   4 sw_in=8'h3C stable 3+ cycles, READ SW_ADDR -> read_data=16'h003C.
//   5 READ 9'h1FF, then mem_cmd=11 -> each: mem_ready+bus_err pulse together, read_data unchanged.
//   6 Back-to-back READ 9'h0FF and READ 9'h000 held continuously -> two mem_ready pulses,
//     exactly two RAM accesses, correct data for each.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: bus controller between the CPU core and a synchronous RAM plus LED/switch IO.
// Each accepted request gets exactly one mem_ready pulse. bus_err is pulsed alongside
// mem_ready for unmapped or illegal requests.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   mem_cmd_i          00 none, 01 read, 10 write, 11 illegal
//   mem_addr_i         word address from the core
//   write_data_i       store data from the core
//   read_data_o        load data, held until the next successful read
//   mem_ready_o        one-cycle completion pulse
//   bus_err_o          one-cycle error pulse, coincident with mem_ready_o
//   ram_addr_o         RAM address (registered at accept)
//   ram_we_o           RAM write enable (single cycle)
//   ram_wdata_o        RAM write data (registered at accept)
//   ram_rdata_i        RAM read data, valid one cycle after ram_addr_o
//   sw_in_i            asynchronous slide switches
//   led_out_o          LED register
module mem_bus_ctrl #(
  parameter int unsigned           ADDR_W   = 9,
  parameter int unsigned           DATA_W   = 16,
  parameter int unsigned           RAM_AW   = 8,
  parameter logic [ADDR_W-1:0]     LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0]     SW_ADDR  = 9'h140
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mem_cmd_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] write_data_i,
  output logic [DATA_W-1:0] read_data_o,
  output logic              mem_ready_o,
  output logic              bus_err_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  input  logic [7:0]        sw_in_i,
  output logic [7:0]        led_out_o
);

  typedef enum logic [2:0] {StIdle, StRdWait, StRdCap, StWr, StResp} state_e;

  localparam logic [1:0] CmdNone  = 2'b00;
  localparam logic [1:0] CmdRead  = 2'b01;
  localparam logic [1:0] CmdWrite = 2'b10;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              mem_ready_q, mem_ready_d;
  logic              bus_err_q, bus_err_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [7:0]        led_q, led_d;
  logic [7:0]        sw_meta_q, sw_sync_q;

  logic is_ram, is_led, is_sw;

  // RAM occupies the lower half of the address space (top address bit clear).
  assign is_ram = ~mem_addr_i[ADDR_W-1];
  assign is_led = (mem_addr_i == LED_ADDR);
  assign is_sw  = (mem_addr_i == SW_ADDR);

  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    led_d       = led_q;
    bus_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mem_cmd_i != CmdNone) begin
          // Anything not explicitly mapped falls through to an error response
          // that leaves all architectural state untouched.
          state_d   = StResp;
          bus_err_d = 1'b1;
          if (mem_cmd_i == CmdRead) begin
            if (is_ram) begin
              state_d    = StRdWait;
              bus_err_d  = 1'b0;
              ram_addr_d = mem_addr_i[RAM_AW-1:0];
            end else if (is_sw) begin
              bus_err_d   = 1'b0;
              read_data_d = {{(DATA_W-8){1'b0}}, sw_sync_q};
            end
          end else if (mem_cmd_i == CmdWrite) begin
            if (is_ram) begin
              state_d     = StWr;
              bus_err_d   = 1'b0;
              ram_addr_d  = mem_addr_i[RAM_AW-1:0];
              ram_wdata_d = write_data_i;
            end else if (is_led) begin
              bus_err_d = 1'b0;
              led_d     = write_data_i[7:0];
            end
          end
        end
      end
      StRdWait: state_d = StRdCap;
      StRdCap: begin
        read_data_d = ram_rdata_i;
        state_d     = StResp;
      end
      StWr:     state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Outputs are registered so they line up with the state being entered.
    mem_ready_d = (state_d == StResp);
    ram_we_d    = (state_d == StWr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      read_data_q <= '0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      led_q       <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
      mem_ready_q <= mem_ready_d;
      bus_err_q   <= bus_err_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      led_q       <= led_d;
      sw_meta_q   <= sw_in_i;
      sw_sync_q   <= sw_meta_q;
    end
  end

  assign read_data_o = read_data_q;
  assign mem_ready_o = mem_ready_q;
  assign bus_err_o   = bus_err_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_we_o    = ram_we_q;
  assign ram_wdata_o = ram_wdata_q;
  assign led_out_o   = led_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a behavioural synchronous 256x16 RAM.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ready;
  logic        bus_err;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [7:0]  sw_in;
  logic [7:0]  led_out;

  int n_chk  = 0;
  int n_pass = 0;
  int rdy_cnt = 0;
  int we_cnt  = 0;
  logic [7:0] we_addr = '0;

  logic [15:0] ram_mem [256];

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_cmd_i    (mem_cmd),
    .mem_addr_i   (mem_addr),
    .write_data_i (write_data),
    .read_data_o  (read_data),
    .mem_ready_o  (mem_ready),
    .bus_err_o    (bus_err),
    .ram_addr_o   (ram_addr),
    .ram_we_o     (ram_we),
    .ram_wdata_o  (ram_wdata),
    .ram_rdata_i  (ram_rdata),
    .sw_in_i      (sw_in),
    .led_out_o    (led_out)
  );

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  always @(posedge clk) begin
    if (mem_ready) rdy_cnt++;
    if (ram_we) begin
      we_cnt++;
      we_addr = ram_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Issue one request from IDLE, hold it until mem_ready, then drop to NONE and
  // let the controller return to IDLE. lat counts cycles from accept to mem_ready.
  task automatic access(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wd,
                        output int lat, output logic err);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wd;
    lat        = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!mem_ready && lat < 20);
    if (!mem_ready) check("timeout", 32'(lat), 32'd0);
    err     = bus_err;
    mem_cmd = 2'b00;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    int          lat2;
    int          r0;
    int          w0;
    logic        err;
    logic [15:0] d1;
    logic [15:0] d2;

    mem_cmd    = 2'b00;
    mem_addr   = '0;
    write_data = '0;
    sw_in      = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst read_data", 32'(read_data), 32'h0);
    check("rst mem_ready", 32'(mem_ready), 32'h0);
    check("rst ram_we", 32'(ram_we), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LED write: 1-cycle latency, no error
    access(2'b10, 9'h100, 16'h12A5, lat, err);
    check("led lat", 32'(lat), 32'd1);
    check("led err", 32'(err), 32'd0);
    check("led_out", 32'(led_out), 32'hA5);
    check("ready pulse width", 32'(mem_ready), 32'd0);

    // RAM write then read
    w0 = we_cnt;
    access(2'b10, 9'h005, 16'hBEEF, lat, err);
    check("wr lat", 32'(lat), 32'd2);
    check("wr err", 32'(err), 32'd0);
    check("wr we count", 32'(we_cnt - w0), 32'd1);
    check("wr we addr", 32'(we_addr), 32'h05);
    check("wr read_data kept", 32'(read_data), 32'h0);
    access(2'b01, 9'h005, 16'h0000, lat, err);
    check("rd lat", 32'(lat), 32'd3);
    check("rd err", 32'(err), 32'd0);
    check("rd data", 32'(read_data), 32'hBEEF);

    // Reset in the middle of a RAM read
    mem_cmd  = 2'b01;
    mem_addr = 9'h005;
    @(posedge clk);
    #1;
    r0 = rdy_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst read_data", 32'(read_data), 32'h0);
    check("midrst led_out", 32'(led_out), 32'h0);
    check("midrst ram_addr", 32'(ram_addr), 32'h0);
    check("midrst ram_wdata", 32'(ram_wdata), 32'h0);
    check("midrst mem_ready", 32'(mem_ready), 32'h0);
    check("midrst bus_err", 32'(bus_err), 32'h0);
    mem_cmd = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midrst no ready", 32'(rdy_cnt - r0), 32'd0);
    access(2'b01, 9'h005, 16'h0000, lat, err);
    check("post-rst rd lat", 32'(lat), 32'd3);
    check("post-rst rd data", 32'(read_data), 32'hBEEF);

    // Switch read through the synchronizer
    sw_in = 8'h3C;
    repeat (4) @(posedge clk);
    #1;
    access(2'b01, 9'h140, 16'h0000, lat, err);
    check("sw lat", 32'(lat), 32'd1);
    check("sw err", 32'(err), 32'd0);
    check("sw data", 32'(read_data), 32'h003C);

    // Error cases: unmapped read, illegal cmd, write to SW, read of LED
    access(2'b01, 9'h1FF, 16'h0000, lat, err);
    check("unmapped lat", 32'(lat), 32'd1);
    check("unmapped err", 32'(err), 32'd1);
    check("unmapped data kept", 32'(read_data), 32'h003C);
    w0 = we_cnt;
    access(2'b11, 9'h005, 16'hFFFF, lat, err);
    check("cmd11 lat", 32'(lat), 32'd1);
    check("cmd11 err", 32'(err), 32'd1);
    check("cmd11 data kept", 32'(read_data), 32'h003C);
    check("cmd11 no ram write", 32'(we_cnt - w0), 32'd0);
    access(2'b10, 9'h140, 16'h00FF, lat, err);
    check("wr sw err", 32'(err), 32'd1);
    check("wr sw led kept", 32'(led_out), 32'h00);
    access(2'b01, 9'h100, 16'h0000, lat, err);
    check("rd led err", 32'(err), 32'd1);
    check("rd led data kept", 32'(read_data), 32'h003C);

    // Back-to-back reads of the last and first RAM words
    access(2'b10, 9'h0FF, 16'h1234, lat, err);
    access(2'b10, 9'h000, 16'h5678, lat, err);
    r0 = rdy_cnt;
    w0 = we_cnt;
    mem_cmd  = 2'b01;
    mem_addr = 9'h0FF;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!mem_ready && lat < 20);
    d1 = read_data;
    mem_addr = 9'h000;
    lat2 = 0;
    do begin
      @(posedge clk);
      #1;
      lat2++;
    end while (!mem_ready && lat2 < 20);
    d2 = read_data;
    mem_cmd = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("b2b lat1", 32'(lat), 32'd3);
    check("b2b lat2", 32'(lat2), 32'd4);
    check("b2b data1", 32'(d1), 32'h1234);
    check("b2b data2", 32'(d2), 32'h5678);
    check("b2b ready count", 32'(rdy_cnt - r0), 32'd2);
    check("b2b no writes", 32'(we_cnt - w0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
